ldpc_iter_ctrl: RTL and testbench

Parametrised iteration controller for the K×K PE-block LDPC decoder array. It loads one frame's intrinsic messages, then sequences check-node and variable-node phases over L addresses. It terminates early when every CNU parity bit is clear, or stops after MAX_ITER iterations, and finally streams the decoded words out. It replaces free-running `f_id`/`relay` generation at the decoder top with a handshaked, frame-level schedule.

---
 rtl/ldpc_iter_ctrl_if.sv | 39 +++
 rtl/ldpc_iter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_iter_ctrl_if.sv
// Frame-level handshake bundle between the LDPC iteration controller and the
// PE array, intrinsic loader and decoded-word sink.
interface ldpc_iter_ctrl_if #(
  parameter int K          = 6,
  parameter int J          = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int ITER_WIDTH = 4
);
  logic                  start;
  logic                  abort;
  logic                  load_valid;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] load_add;
  logic [K-1:0]          column_select;
  logic                  cnu_en;
  logic                  f_id;
  logic                  relay;
  logic [J*K-1:0]        p_bit;
  logic [ADDR_WIDTH-1:0] read_add;
  logic                  dec_valid;
  logic                  dec_ready;
  logic                  dec_last;
  logic                  busy;
  logic                  done;
  logic                  converged;
  logic [ITER_WIDTH-1:0] iter_count;

  modport master (
    input  start, abort, load_valid, p_bit, dec_ready,
    output load_ready, load_add, column_select, cnu_en, f_id, relay,
           read_add, dec_valid, dec_last, busy, done, converged, iter_count
  );

  modport slave (
    output start, abort, load_valid, p_bit, dec_ready,
    input  load_ready, load_add, column_select, cnu_en, f_id, relay,
           read_add, dec_valid, dec_last, busy, done, converged, iter_count
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// Frame scheduler for the KxK LDPC decoder: load, check/variable iterations with
// early syndrome exit or iteration cap, then handshaked readout.
module ldpc_iter_ctrl #(
  parameter int K          = 6,
  parameter int J          = 3,
  parameter int L          = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_ITER   = 8,
  parameter int ITER_WIDTH = 4,
  parameter int CNU_LAT    = 4
) (
  input logic              clk,
  input logic              rst_n,
  ldpc_iter_ctrl_if.master bus
);
  localparam int LW = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
  localparam logic [LW-1:0]         LAT_LAST  = LW'(CNU_LAT - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX  = ITER_WIDTH'(MAX_ITER);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, CDRAIN, VAR, READ, DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] load_add_q, read_add_q;
  logic [K-1:0]          col_sel_q;
  logic                  load_ready_q, cnu_en_q, f_id_q, relay_q;
  logic                  dec_valid_q, dec_last_q, busy_q, done_q, converged_q, syn_q;
  logic [ITER_WIDTH-1:0] iter_q;
  logic [LW-1:0]         lat_cnt_q;
  logic [CNU_LAT-1:0]    vld_pipe_q;

  logic [CNU_LAT:0]      vld_pipe;
  logic [J*K-1:0]        p_bit_w;
  logic                  par_hit, syn_d;
  logic [ITER_WIDTH-1:0] iter_d;

  // vld_pipe[n] is cnu_en delayed by n cycles; the tap at CNU_LAT qualifies p_bit.
  assign vld_pipe = {vld_pipe_q, cnu_en_q};
  assign p_bit_w  = bus.p_bit;
  assign par_hit  = vld_pipe[CNU_LAT] & (|p_bit_w);
  assign syn_d    = syn_q | par_hit;
  assign iter_d   = iter_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;     load_add_q <= '0;    read_add_q <= '0;   col_sel_q <= '0;
      load_ready_q <= 1'b0; cnu_en_q <= 1'b0;   f_id_q <= 1'b0;     relay_q <= 1'b0;
      dec_valid_q <= 1'b0; dec_last_q <= 1'b0;  busy_q <= 1'b0;     done_q <= 1'b0;
      converged_q <= 1'b0; syn_q <= 1'b0;       iter_q <= '0;       lat_cnt_q <= '0;
      vld_pipe_q <= '0;
    end else if (bus.abort) begin
      state_q <= IDLE;     load_add_q <= '0;    read_add_q <= '0;   col_sel_q <= '0;
      load_ready_q <= 1'b0; cnu_en_q <= 1'b0;   f_id_q <= 1'b0;     relay_q <= 1'b0;
      dec_valid_q <= 1'b0; dec_last_q <= 1'b0;  busy_q <= 1'b0;     done_q <= 1'b0;
      converged_q <= 1'b0; syn_q <= 1'b0;       iter_q <= '0;       lat_cnt_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe[CNU_LAT-1:0];
      if (par_hit) syn_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q      <= LOAD;
          load_ready_q <= 1'b1;
          busy_q       <= 1'b1;
          col_sel_q    <= K'(1);
          load_add_q   <= '0;
          iter_q       <= '0;
          converged_q  <= 1'b0;
        end
        LOAD: if (bus.load_valid) begin
          if (load_add_q == ADDR_LAST) begin
            load_add_q <= '0;
            if (col_sel_q[K-1]) begin
              state_q      <= CHECK;
              load_ready_q <= 1'b0;
              col_sel_q    <= '0;
              cnu_en_q     <= 1'b1;
              read_add_q   <= '0;
              syn_q        <= 1'b0;
            end else begin
              col_sel_q <= col_sel_q << 1;
            end
          end else begin
            load_add_q <= load_add_q + 1'b1;
          end
        end
        CHECK: if (read_add_q == ADDR_LAST) begin
          state_q   <= CDRAIN;
          cnu_en_q  <= 1'b0;
          lat_cnt_q <= '0;
        end else begin
          read_add_q <= read_add_q + 1'b1;
        end
        // The last in-flight parity sample lands on the final drain cycle.
        CDRAIN: if (lat_cnt_q == LAT_LAST) begin
          vld_pipe_q <= '0;
          read_add_q <= '0;
          if (syn_d) begin
            state_q <= VAR;
            f_id_q  <= 1'b1;
            relay_q <= 1'b1;
          end else begin
            state_q     <= READ;
            converged_q <= 1'b1;
            dec_valid_q <= 1'b1;
            dec_last_q  <= (L == 1);
          end
        end else begin
          lat_cnt_q <= lat_cnt_q + 1'b1;
        end
        VAR: if (read_add_q == ADDR_LAST) begin
          iter_q     <= iter_d;
          read_add_q <= '0;
          f_id_q     <= 1'b0;
          relay_q    <= 1'b0;
          if (iter_d == ITER_MAX) begin
            state_q     <= READ;
            dec_valid_q <= 1'b1;
            dec_last_q  <= (L == 1);
          end else begin
            state_q  <= CHECK;
            cnu_en_q <= 1'b1;
            syn_q    <= 1'b0;
          end
        end else begin
          read_add_q <= read_add_q + 1'b1;
        end
        READ: if (bus.dec_ready) begin
          if (read_add_q == ADDR_LAST) begin
            state_q     <= DONE;
            dec_valid_q <= 1'b0;
            dec_last_q  <= 1'b0;
            read_add_q  <= '0;
            done_q      <= 1'b1;
          end else begin
            read_add_q <= read_add_q + 1'b1;
            dec_last_q <= ((read_add_q + 1'b1) == ADDR_LAST);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.load_ready    = load_ready_q;
  assign bus.load_add      = load_add_q;
  assign bus.column_select = col_sel_q;
  assign bus.cnu_en        = cnu_en_q;
  assign bus.f_id          = f_id_q;
  assign bus.relay         = relay_q;
  assign bus.read_add      = read_add_q;
  assign bus.dec_valid     = dec_valid_q;
  assign bus.dec_last      = dec_last_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.converged     = converged_q;
  assign bus.iter_count    = iter_q;
endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Randomized frame-level bench for ldpc_iter_ctrl; expected behaviour comes from
// a phase-level model of the frame schedule and syndrome rule.
module tb_ldpc_iter_ctrl;
  localparam int K = 6, J = 3, L = 32, AW = 5, MAX_ITER = 8, IW = 4, CNU_LAT = 4;
  localparam int PW = J * K;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  ldpc_iter_ctrl_if #(.K(K), .J(J), .ADDR_WIDTH(AW), .ITER_WIDTH(IW)) bus ();

  ldpc_iter_ctrl #(
    .K(K), .J(J), .L(L), .ADDR_WIDTH(AW), .MAX_ITER(MAX_ITER),
    .ITER_WIDTH(IW), .CNU_LAT(CNU_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_load_ready"}, 32'(bus.load_ready), 0);
    chk({pfx, "_load_add"},   32'(bus.load_add), 0);
    chk({pfx, "_col_sel"},    32'(bus.column_select), 0);
    chk({pfx, "_cnu_en"},     32'(bus.cnu_en), 0);
    chk({pfx, "_f_id"},       32'(bus.f_id), 0);
    chk({pfx, "_relay"},      32'(bus.relay), 0);
    chk({pfx, "_read_add"},   32'(bus.read_add), 0);
    chk({pfx, "_dec_valid"},  32'(bus.dec_valid), 0);
    chk({pfx, "_dec_last"},   32'(bus.dec_last), 0);
    chk({pfx, "_busy"},       32'(bus.busy), 0);
    chk({pfx, "_done"},       32'(bus.done), 0);
    chk({pfx, "_converged"},  32'(bus.converged), 0);
    chk({pfx, "_iter"},       32'(bus.iter_count), 0);
  endtask

  // Parity pattern per check-phase cycle c (0 = first CHECK cycle) of iteration it.
  function automatic logic [PW-1:0] pbit_for(input int mode, input int it, input int c);
    logic [PW-1:0] r;
    r = '0;
    case (mode)
      0: if (c < CNU_LAT) r = PW'($urandom);
      1: r[0] = 1'b1;
      2: if (c < CNU_LAT) r = PW'($urandom);
         else if ($urandom_range(0, 39) == 0) r[$urandom_range(0, PW-1)] = 1'b1;
      3: if (it == 0 && c == 0) r[5] = 1'b1;
      4: if (it == 0 && c == CNU_LAT) r[PW-1] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic start_and_load(input int stall_pct);
    int  beats, guard;
    bit  lv;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_iter", 32'(bus.iter_count), 0);
    chk("start_conv", 32'(bus.converged), 0);
    beats = 0;
    guard = 0;
    while (beats < K * L && guard < 20 * K * L) begin
      chk("load_ready", 32'(bus.load_ready), 1);
      chk("load_add",   32'(bus.load_add), beats % L);
      chk("col_sel",    32'(bus.column_select), 1 << (beats / L));
      chk("load_cnu",   32'(bus.cnu_en), 0);
      lv = ($urandom_range(0, 99) >= stall_pct);
      bus.load_valid = lv;
      bus.p_bit = PW'($urandom);
      tick;
      guard++;
      if (lv) beats++;
    end
    chk("load_beats", beats, K * L);
    bus.load_valid = 1'b0;
  endtask

  task automatic run_frame(input int pmode, input int stall_pct, input int rdy_mode);
    bit            syn, exp_conv, tog, r;
    int            exp_iter, exp_a, guard;
    logic [PW-1:0] p;
    start_and_load(stall_pct);
    exp_conv = 1'b0;
    exp_iter = MAX_ITER;
    for (int it = 0; it < MAX_ITER; it++) begin
      syn = 1'b0;
      for (int c = 0; c < L + CNU_LAT; c++) begin
        chk("chk_cnu_en", 32'(bus.cnu_en), 32'(c < L));
        chk("chk_f_id",   32'(bus.f_id), 0);
        chk("chk_relay",  32'(bus.relay), 0);
        chk("chk_iter",   32'(bus.iter_count), it);
        chk("chk_busy",   32'(bus.busy), 1);
        chk("chk_lready", 32'(bus.load_ready), 0);
        if (c < L) chk("chk_addr", 32'(bus.read_add), c);
        p = pbit_for(pmode, it, c);
        if (c >= CNU_LAT && p != '0) syn = 1'b1;
        bus.p_bit = p;
        bus.start = 1'($urandom_range(0, 1));
        bus.load_valid = 1'($urandom_range(0, 1));
        tick;
      end
      if (!syn) begin
        exp_conv = 1'b1;
        exp_iter = it;
        break;
      end
      for (int v = 0; v < L; v++) begin
        chk("var_f_id",  32'(bus.f_id), 1);
        chk("var_relay", 32'(bus.relay), 1);
        chk("var_cnu",   32'(bus.cnu_en), 0);
        chk("var_addr",  32'(bus.read_add), v);
        chk("var_dval",  32'(bus.dec_valid), 0);
        bus.p_bit = PW'($urandom);
        bus.start = 1'($urandom_range(0, 1));
        tick;
      end
    end
    bus.start = 1'b0;
    bus.load_valid = 1'b0;
    chk("read_conv", 32'(bus.converged), 32'(exp_conv));
    chk("read_iter", 32'(bus.iter_count), exp_iter);
    chk("read_relay", 32'(bus.relay), 0);
    exp_a = 0;
    guard = 0;
    tog = 1'b0;
    while (exp_a < L && guard < 20 * L) begin
      chk("rd_valid", 32'(bus.dec_valid), 1);
      chk("rd_addr",  32'(bus.read_add), exp_a);
      chk("rd_last",  32'(bus.dec_last), 32'(exp_a == L - 1));
      chk("rd_done",  32'(bus.done), 0);
      case (rdy_mode)
        0: r = 1'b1;
        1: begin r = tog; tog = !tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.dec_ready = r;
      bus.p_bit = PW'($urandom);
      tick;
      guard++;
      if (r) exp_a++;
    end
    chk("rd_beats", exp_a, L);
    bus.dec_ready = 1'b0;
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_dval",  32'(bus.dec_valid), 0);
    chk("done_busy",  32'(bus.busy), 1);
    tick;
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("hold_conv", 32'(bus.converged), 32'(exp_conv));
    chk("hold_iter", 32'(bus.iter_count), exp_iter);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.load_valid = 1'b0;
    bus.p_bit = '0;
    bus.dec_ready = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    check_zero("rst");
    rst_n = 1'b1;
    tick;
    check_zero("post_rst");

    // start together with abort: controller must stay idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy",  32'(bus.busy), 0);
    chk("sa_ready", 32'(bus.load_ready), 0);

    run_frame(0, 0, 0);   // clean syndrome: READ after one check phase
    run_frame(1, 0, 1);   // never clears: iteration cap, toggled ready
    run_frame(3, 0, 0);   // parity pulse before the valid window
    run_frame(4, 10, 2);  // parity pulse at the first valid sample
    for (int i = 0; i < 6; i++) run_frame(2, 30, 2);

    // abort during CDRAIN
    start_and_load(0);
    for (int c = 0; c < L; c++) begin
      bus.p_bit = PW'(1);
      tick;
    end
    chk("ab_cdrain_cnu", 32'(bus.cnu_en), 0);
    chk("ab_cdrain_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check_zero("abort");
    for (int c = 0; c < CNU_LAT + 2; c++) begin
      bus.p_bit = PW'($urandom);
      tick;
      chk("ab_idle_busy", 32'(bus.busy), 0);
      chk("ab_idle_fid",  32'(bus.f_id), 0);
    end
    run_frame(0, 20, 2);

    // asynchronous reset in the middle of VAR
    start_and_load(0);
    for (int c = 0; c < L + CNU_LAT + 5; c++) begin
      bus.p_bit = PW'(1);
      tick;
    end
    chk("pre_rst_relay", 32'(bus.relay), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check_zero("rst_rel");
    run_frame(2, 20, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
